cache_mem_ctrl: RTL

Memory-side controller between the data cache and the slow main memory. It queues the cache's dirty-eviction write-backs in a small posted write buffer, and it services cache read misses with a single-word refill. Refills are forwarded from the buffer when the buffer holds the requested word. Writes are drained to memory over a req/ready handshake. It asserts stall back to the pipeline while a miss is outstanding or the buffer is full.

---
 rtl/cache_mem_ctrl.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl
// ----------------------------------------------------------------------------
// Memory-side controller between the data cache and main memory.
// It does three jobs:
//   - It queues dirty-eviction write-backs in a small posted write buffer.
//   - It services read misses with a single-word refill. The refill is
//     forwarded straight from the write buffer when the buffer (or the
//     eviction arriving in the same cycle) holds the requested word.
//   - It drains buffered writes to memory over a req/ready handshake.
//
// Ports
//   CLK, RST       clock; synchronous active-high reset
//   miss_req       read miss, level, held until refill_valid
//   miss_addr      byte address of the missing word
//   wb_req         one-cycle pulse per dirty eviction
//   wb_addr        byte address of the evicted word
//   wb_data        evicted word
//   stall          pipeline stall (combinational)
//   refill_valid   one-cycle pulse, refill_data valid
//   refill_data    refill word
//   wb_full        write buffer holds WB_DEPTH entries
//   mem_req        memory request
//   mem_we         memory direction (1 = write)
//   mem_addr       word-aligned memory address
//   mem_wdata      memory write data
//   mem_ready      memory accepts/completes the request at this edge
//   mem_rdata      memory read data
//   miss_count     accepted misses, saturating
// ----------------------------------------------------------------------------
module cache_mem_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned WB_DEPTH   = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  miss_req,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic                  wb_req,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  stall,
    output logic                  refill_valid,
    output logic [DATA_WIDTH-1:0] refill_data,
    output logic                  wb_full,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [31:0]           miss_count
);

    localparam int unsigned PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WADDR_W = ADDR_WIDTH - 2;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WB_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRefill,
        StDrain,
        StRespond
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                r_state;
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    // Buffer storage keeps only the word address; the byte offset is never
    // used for compare or for the memory address.
    logic [WADDR_W-1:0]    r_wb_addr [WB_DEPTH];
    logic [DATA_WIDTH-1:0] r_wb_data [WB_DEPTH];

    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_refill_valid;
    logic [DATA_WIDTH-1:0] r_refill_data;
    logic [31:0]           r_miss_count;

    // ------------------------------------------------------------------------
    // Buffer handshake decode
    // ------------------------------------------------------------------------
    logic                  w_full;
    logic                  w_enq;
    logic                  w_deq;
    logic [WADDR_W-1:0]    w_miss_waddr;
    logic [WADDR_W-1:0]    w_wb_waddr;

    assign w_full       = (r_count == FULL_CNT);
    // A write-back offered while full is dropped.
    assign w_enq        = wb_req && !w_full;
    // mem_ready only counts while a request is actually outstanding.
    assign w_deq        = (r_state == StDrain) && r_mem_req && mem_ready;
    assign w_miss_waddr = miss_addr[ADDR_WIDTH-1:2];
    assign w_wb_waddr   = wb_addr[ADDR_WIDTH-1:2];

    // ------------------------------------------------------------------------
    // Forwarding match: scan oldest to youngest so the last hit is the
    // youngest; the eviction arriving this cycle is younger than all of them.
    // ------------------------------------------------------------------------
    logic                  w_fwd_hit;
    logic [DATA_WIDTH-1:0] w_fwd_data;
    logic [PTR_W-1:0]      w_idx;

    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_wb_addr[w_idx] == w_miss_waddr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_wb_data[w_idx];
            end
        end
        if (w_enq && (w_wb_waddr == w_miss_waddr)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = wb_data;
        end
    end

    // ------------------------------------------------------------------------
    // Buffer storage (no reset needed: validity comes from the count)
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_wb_addr[r_tail] <= w_wb_waddr;
            r_wb_data[r_tail] <= wb_data;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers, count and controller FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= StIdle;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_refill_valid <= 1'b0;
            r_refill_data  <= '0;
            r_miss_count   <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_deq) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - CNT_W'(1);
            end

            // refill_valid is a single-cycle pulse unless re-armed below.
            r_refill_valid <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (miss_req) begin
                        if (r_miss_count != '1) begin
                            r_miss_count <= r_miss_count + 32'd1;
                        end
                        if (w_fwd_hit) begin
                            r_refill_data  <= w_fwd_data;
                            r_refill_valid <= 1'b1;
                            r_state        <= StRespond;
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= {w_miss_waddr, 2'b00};
                            r_state    <= StRefill;
                        end
                    end else if (r_count != '0) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {r_wb_addr[r_head], 2'b00};
                        r_mem_wdata <= r_wb_data[r_head];
                        r_state     <= StDrain;
                    end
                end
                StRefill: begin
                    if (r_mem_req && mem_ready) begin
                        r_refill_data  <= mem_rdata;
                        r_refill_valid <= 1'b1;
                        r_mem_req      <= 1'b0;
                        r_state        <= StRespond;
                    end
                end
                StDrain: begin
                    // Never preempted; a pending miss waits for the handshake.
                    if (w_deq) begin
                        r_mem_req <= 1'b0;
                        r_state   <= StIdle;
                    end
                end
                StRespond: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign wb_full      = w_full;
    assign stall        = (miss_req && !r_refill_valid) || w_full;
    assign refill_valid = r_refill_valid;
    assign refill_data  = r_refill_data;
    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign miss_count   = r_miss_count;

endmodule
